// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - default requant widths and shared round/range helpers
package dct_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_FRAC  = 7;
  localparam int DEF_OUT_W = 9;

  // Round-half-up: add half an LSB of the result, then arithmetic shift (floor).
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] value,
                                                     input int frac);
    logic signed [63:0] half;
    half = 64'sd1 <<< (frac - 1);
    return (value + half) >>> frac;
  endfunction

  function automatic logic fits_signed(input logic signed [63:0] value, input int w);
    logic signed [63:0] lim;
    lim = 64'sd1 <<< (w - 1);
    return (value >= -lim) && (value < lim);
  endfunction

endpackage

// File: rtl/rq_lane.sv
// rtl/rq_lane.sv - one requant lane: round into S1, narrow/overflow-detect from S1
// ROT_REQUANT_SAT_EN selects saturation on out-of-range results instead of wrap.
module rq_lane
  import dct_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic [2*WIDTH-1:0]    in_y,
  output logic [2*WIDTH-FRAC:0] r,
  input  logic [2*WIDTH-FRAC:0] s1_r,
  output logic [OUT_W-1:0]      narrow,
  output logic                  oor
);

  localparam int IW = 2 * WIDTH;
  localparam int RW = IW + 1 - FRAC;

  logic signed [63:0] s1_ext;

  always_comb begin
    r      = RW'(round_shift({{(64-IW){in_y[IW-1]}}, in_y}, FRAC));
    s1_ext = {{(64-RW){s1_r[RW-1]}}, s1_r};
    oor    = !fits_signed(s1_ext, OUT_W);
`ifdef ROT_REQUANT_SAT_EN
    if (oor) begin
      narrow = s1_r[RW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      narrow = s1_r[OUT_W-1:0];
    end
`else
    narrow = s1_r[OUT_W-1:0];
`endif
  end

endmodule

// File: rtl/rot_requant.sv
// rtl/rot_requant.sv - 2-deep valid/ready round+narrow stage after the DCT rotation
// ROT_REQUANT_SAT_EN (in rq_lane) selects saturation; default build wraps.
module rot_requant
  import dct_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] in_y0,
  input  logic [2*WIDTH-1:0] in_y1,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_y0,
  output logic [OUT_W-1:0]   out_y1,
  output logic               ovf,
  input  logic               clr_ovf
);

  localparam int RW = 2 * WIDTH + 1 - FRAC;

  logic [RW-1:0]    r0_q, r0_d, r1_q, r1_d;
  logic             s1_v_q, s1_v_d;
  logic [OUT_W-1:0] out_y0_q, out_y0_d, out_y1_q, out_y1_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q, ovf_d;

  logic [RW-1:0]    rn0, rn1;
  logic [OUT_W-1:0] nw0, nw1;
  logic             oor0, oor1;
  logic             adv1, adv2;

  rq_lane #(.WIDTH(WIDTH), .FRAC(FRAC), .OUT_W(OUT_W)) u_lane0 (
    .in_y(in_y0), .r(rn0), .s1_r(r0_q), .narrow(nw0), .oor(oor0)
  );

  rq_lane #(.WIDTH(WIDTH), .FRAC(FRAC), .OUT_W(OUT_W)) u_lane1 (
    .in_y(in_y1), .r(rn1), .s1_r(r1_q), .narrow(nw1), .oor(oor1)
  );

  always_comb begin
    adv2        = ~out_valid_q | out_ready;
    adv1        = ~s1_v_q | adv2;
    r0_d        = r0_q;
    r1_d        = r1_q;
    s1_v_d      = s1_v_q;
    out_y0_d    = out_y0_q;
    out_y1_d    = out_y1_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;

    if (in_valid && adv1) begin
      s1_v_d = 1'b1;
      r0_d   = rn0;
      r1_d   = rn1;
    end else if (adv2) begin
      s1_v_d = 1'b0;
    end

    if (adv2) begin
      out_valid_d = s1_v_q;
      out_y0_d    = nw0;
      out_y1_d    = nw1;
    end

    // Only valid S1 data can flag overflow; a set beats a same-cycle clear.
    if (adv2 && s1_v_q && (oor0 || oor1)) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_q        <= '0;
      r1_q        <= '0;
      s1_v_q      <= 1'b0;
      out_y0_q    <= '0;
      out_y1_q    <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      r0_q        <= r0_d;
      r1_q        <= r1_d;
      s1_v_q      <= s1_v_d;
      out_y0_q    <= out_y0_d;
      out_y1_q    <= out_y1_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = adv1;
  assign out_valid = out_valid_q;
  assign out_y0    = out_y0_q;
  assign out_y1    = out_y1_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_rot_requant.sv
// tb/tb_rot_requant.sv - directed self-checking bench for rot_requant (WIDTH=8, FRAC=7, OUT_W=9)
module tb_rot_requant;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_y0, in_y1;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_y0, out_y1;
  logic        ovf;
  logic        clr_ovf;

  typedef struct packed {
    logic [8:0] y0;
    logic [8:0] y1;
  } pair_t;

  pair_t exp_q[$];
  int    out_cyc[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;

  rot_requant #(.WIDTH(8), .FRAC(7), .OUT_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_y0(in_y0), .in_y1(in_y1), .out_valid(out_valid), .out_ready(out_ready),
    .out_y0(out_y0), .out_y1(out_y1), .ovf(ovf), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: floor((x + 64) / 128), then clamp or wrap to 9 bits.
  function automatic logic [8:0] exp_lane(input logic [15:0] x);
    int v, e;
    v = int'($signed(x));
    e = (v + 64) >>> 7;
`ifdef ROT_REQUANT_SAT_EN
    if (e > 255)  e = 255;
    if (e < -256) e = -256;
`endif
    return e[8:0];
  endfunction

  function automatic pair_t exp_pair(input logic [15:0] a, input logic [15:0] b);
    pair_t p;
    p.y0 = exp_lane(a);
    p.y1 = exp_lane(b);
    return p;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        pair_t p;
        p = exp_q.pop_front();
        check("mon_y0", {23'd0, out_y0}, {23'd0, p.y0});
        check("mon_y1", {23'd0, out_y1}, {23'd0, p.y1});
      end
      out_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b);
    bit ok;
    ok = 1'b0;
    in_y0 = a;
    in_y1 = b;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drive_timeout", 32'd0, 32'd1);
    else exp_q.push_back(exp_pair(a, b));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  logic [15:0] vec_a[4] = '{16'h003F, 16'hFFBF, 16'h7F80, 16'h7FC0};
  logic [15:0] vec_b[4] = '{16'hFFBF, 16'h8000, 16'h0080, 16'hFF3F};

  initial begin
    int          start, acc;
    logic [8:0]  hold0, hold1;
    logic [15:0] a, b;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_ovf = 1'b0;
    in_y0 = '0; in_y1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_y0", {23'd0, out_y0}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    step();

    // Rounding and two-cycle latency
    drive(16'h0040, 16'hFFC0);
    check("lat_not_yet", {31'd0, out_valid}, 32'd0);
    step();
    check("lat_valid", {31'd0, out_valid}, 32'd1);
    check("round_y0", {23'd0, out_y0}, 32'd1);
    check("round_y1", {23'd0, out_y1}, 32'd0);
    check("round_ovf", {31'd0, ovf}, 32'd0);
    step();

    for (int i = 0; i < 4; i++) drive(vec_a[i], vec_b[i]);
    repeat (3) step();
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;

    // Range extremes
    drive(16'h7FFF, 16'h8000);
    step();
`ifdef ROT_REQUANT_SAT_EN
    check("range_y0", {23'd0, out_y0}, 32'h0FF);
`else
    check("range_y0", {23'd0, out_y0}, 32'h100);
`endif
    check("range_y1", {23'd0, out_y1}, 32'h100);
    check("range_ovf", {31'd0, ovf}, 32'd1);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    check("clr_ovf_alone", {31'd0, ovf}, 32'd0);

    // Set beats clear in the same cycle
    clr_ovf = 1'b1;
    drive(16'h7FFF, 16'h0000);
    step();
    check("ovf_set_wins", {31'd0, ovf}, 32'd1);
    step();
    check("ovf_clr_next", {31'd0, ovf}, 32'd0);
    clr_ovf = 1'b0;
    step();

    // Throughput: 16 back-to-back pairs
    start = out_cyc.size();
    for (int i = 0; i < 16; i++) begin
      a = 16'(i * 16'h0815);
      b = 16'(16'hF000 + i * 16'h0123);
      in_y0 = a; in_y1 = b; in_valid = 1'b1;
      @(negedge clk);
      check("tp_in_ready", {31'd0, in_ready}, 32'd1);
      exp_q.push_back(exp_pair(a, b));
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    check("tp_count", out_cyc.size() - start, 32'd16);
    if (out_cyc.size() - start == 16)
      check("tp_consecutive", out_cyc[start+15] - out_cyc[start], 32'd15);

    // Backpressure: 5 stalled cycles while offering data
    start = out_cyc.size();
    out_ready = 1'b0; acc = 0;
    a = 16'h1234; b = 16'hEDCB;
    in_y0 = a; in_y1 = b; in_valid = 1'b1;
    hold0 = '0; hold1 = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp_pair(a, b));
        acc++;
      end
      if (c == 2) begin
        hold0 = out_y0; hold1 = out_y1;
      end else if (c > 2) begin
        check("bp_y0_stable", {23'd0, out_y0}, {23'd0, hold0});
        check("bp_y1_stable", {23'd0, out_y1}, {23'd0, hold1});
      end
      @(posedge clk);
      #1;
      if (in_ready == 1'b0 && acc > 0) ;
      a = a + 16'h0101; b = b - 16'h0303;
      in_y0 = a; in_y1 = b;
    end
    check("bp_accepted", acc, 32'd2);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    check("bp_drained", out_cyc.size() - start, 32'd2);

    // Async reset with two pairs held
    out_ready = 1'b0;
    in_y0 = 16'h7FFF; in_y1 = 16'h7FFF; in_valid = 1'b1;
    step(); step();
    in_valid = 1'b0;
    check("rst_pre_ovf", {31'd0, ovf}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_y0", {23'd0, out_y0}, 32'd0);
    check("mid_rst_out_y1", {23'd0, out_y1}, 32'd0);
    check("mid_rst_ovf", {31'd0, ovf}, 32'd0);
    exp_q.delete();
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    step();
    drive(16'h0040, 16'h0000);
    repeat (3) step();

    check("final_drain", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
